// File: rtl/risc_ctrl_pkg.sv
// Shared types and opcode map for the multi-cycle accumulator controller.
package risc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_OPFETCH = 3'd3,
    S_STORE   = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // States that hold a memory access open until mem_ready.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_OPFETCH) || (s == S_STORE);
  endfunction
endpackage

// File: rtl/risc_wait_timer.sv
// Saturating stall counter; flags a bus timeout once WAIT_MAX stall cycles have elapsed.
module risc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic timeout
);
  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] MAXC = CW'(WAIT_MAX);

  logic [CW-1:0] cnt;
  logic          stall;

  assign stall = active & ~ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt <= '0;
    else if (clear)                 cnt <= '0;
    else if (stall && cnt != MAXC)  cnt <= cnt + 1'b1;
  end

  // A late mem_ready on the limit cycle suppresses the timeout.
  assign timeout = (WAIT_MAX > 0) && stall && (cnt == MAXC);
endmodule

// File: rtl/risc_ctrl_mc.sv
// Multi-cycle controller: fetch/decode/operand/store sequencing with wait handshake,
// bus watchdog, resumable HALT and illegal-opcode trap.
module risc_ctrl_mc
  import risc_ctrl_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            is_zero,
  input  logic            mem_ready,
  input  logic            resume,
  output logic            inc_pc,
  output logic            ld_pc,
  output logic            sel,
  output logic            rd,
  output logic            wr,
  output logic            ld_ir,
  output logic            ld_ac,
  output logic            data_e,
  output logic            halted,
  output logic            bus_err,
  output logic            illegal_op
);
  state_t     state, nxt;
  logic       timeout, set_berr, set_ill, in_wait, st_chg, bad_op;
  logic [2:0] base_op;

  assign base_op = opcode[2:0];
  assign bad_op  = (OP_W > 3) && ((opcode >> 3) != '0);
  assign in_wait = is_wait_state(state);
  assign st_chg  = (nxt != state);

  risc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (in_wait),
    .ready   (mem_ready),
    .clear   (st_chg),
    .timeout (timeout)
  );

  always_comb begin
    nxt      = state;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    sel      = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    ld_ir    = 1'b0;
    ld_ac    = 1'b0;
    data_e   = 1'b0;
    halted   = 1'b0;
    set_berr = 1'b0;
    set_ill  = 1'b0;
    case (state)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        rd = 1'b1;
        if (mem_ready) begin
          ld_ir  = 1'b1;
          inc_pc = 1'b1;
          nxt    = S_DECODE;
        end else if (timeout) begin
          set_berr = 1'b1;
          nxt      = S_HALT;
        end
      end
      S_DECODE: begin
        if (bad_op) begin
          set_ill = 1'b1;
          nxt     = S_HALT;
        end else begin
          case (base_op)
            OP_HLT: nxt = S_HALT;
            OP_SKZ: begin
              inc_pc = is_zero;
              nxt    = S_FETCH;
            end
            OP_STO: nxt = S_STORE;
            OP_JMP: begin
              ld_pc = 1'b1;
              sel   = 1'b1;
              nxt   = S_FETCH;
            end
            default: nxt = S_OPFETCH;
          endcase
        end
      end
      S_OPFETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
        if (mem_ready) begin
          ld_ac = 1'b1;
          nxt   = S_FETCH;
        end else if (timeout) begin
          set_berr = 1'b1;
          nxt      = S_HALT;
        end
      end
      S_STORE: begin
        sel    = 1'b1;
        wr     = 1'b1;
        data_e = 1'b1;
        if (mem_ready) nxt = S_FETCH;
        else if (timeout) begin
          set_berr = 1'b1;
          nxt      = S_HALT;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        // Error halts are sticky until reset.
        if (resume && !bus_err && !illegal_op) nxt = S_FETCH;
      end
      default: nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RESET;
      bus_err    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= nxt;
      bus_err    <= bus_err | set_berr;
      illegal_op <= illegal_op | set_ill;
    end
  end
endmodule

// File: tb/tb_risc_ctrl_mc.sv
// Directed bench for risc_ctrl_mc with an instruction-level reference model checked every cycle.
module tb_risc_ctrl_mc;
  localparam int OP_W     = 4;
  localparam int WAIT_MAX = 4;

  localparam logic [10:0] B_INC  = 11'h400;
  localparam logic [10:0] B_LDPC = 11'h200;
  localparam logic [10:0] B_SEL  = 11'h100;
  localparam logic [10:0] B_RD   = 11'h080;
  localparam logic [10:0] B_WR   = 11'h040;
  localparam logic [10:0] B_IR   = 11'h020;
  localparam logic [10:0] B_AC   = 11'h010;
  localparam logic [10:0] B_DE   = 11'h008;
  localparam logic [10:0] B_HALT = 11'h004;
  localparam logic [10:0] B_BERR = 11'h002;
  localparam logic [10:0] B_ILL  = 11'h001;

  logic clk = 1'b0, rst = 1'b0;
  logic [OP_W-1:0] opcode = '0;
  logic is_zero = 1'b0, mem_ready = 1'b0, resume = 1'b0;
  logic inc_pc, ld_pc, sel, rd, wr, ld_ir, ld_ac, data_e, halted, bus_err, illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  // model: ph 0=reset 1=ifetch 2=decode 3=operand read 4=store 5=halt
  int ph = 0;
  int waited = 0;
  bit m_berr = 0, m_ill = 0;

  risc_ctrl_mc #(.OP_W(OP_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero), .mem_ready(mem_ready),
    .resume(resume), .inc_pc(inc_pc), .ld_pc(ld_pc), .sel(sel), .rd(rd), .wr(wr),
    .ld_ir(ld_ir), .ld_ac(ld_ac), .data_e(data_e), .halted(halted), .bus_err(bus_err),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] dut_vec();
    return {inc_pc, ld_pc, sel, rd, wr, ld_ir, ld_ac, data_e, halted, bus_err, illegal_op};
  endfunction

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h want %03h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [10:0] o;
    o = '0;
    case (ph)
      1: o = B_RD | (mem_ready ? (B_INC | B_IR) : 11'h0);
      2: if (int'(opcode) == 1 && is_zero) o = B_INC;
         else if (int'(opcode) == 7) o = B_LDPC | B_SEL;
      3: o = B_SEL | B_RD | (mem_ready ? B_AC : 11'h0);
      4: o = B_SEL | B_WR | B_DE;
      5: o = B_HALT;
      default: o = '0;
    endcase
    if (m_berr) o |= B_BERR;
    if (m_ill)  o |= B_ILL;
    return o;
  endfunction

  // A memory phase finishes on ready; otherwise it times out after WAIT_MAX stalled cycles.
  task automatic mem_phase(input int done_ph);
    if (mem_ready) begin
      ph = done_ph; waited = 0;
    end else if (WAIT_MAX > 0 && waited == WAIT_MAX) begin
      m_berr = 1; ph = 5; waited = 0;
    end else waited++;
  endtask

  task automatic model_step();
    int op;
    op = int'(opcode);
    case (ph)
      0: begin ph = 1; waited = 0; end
      1: mem_phase(2);
      2: begin
        if (op > 7) begin m_ill = 1; ph = 5; end
        else if (op == 0) ph = 5;
        else if (op == 1 || op == 7) ph = 1;
        else if (op == 6) ph = 4;
        else ph = 3;
        waited = 0;
      end
      3: mem_phase(1);
      4: mem_phase(1);
      5: if (resume && !m_berr && !m_ill) begin ph = 1; waited = 0; end
      default: ph = 0;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        ph = 0; waited = 0; m_berr = 0; m_ill = 0;
      end
      chk($sformatf("cycle_ph%0d", ph), dut_vec(), model_out());
      if (rst) model_step();
    end
  end

  task automatic cyc(input logic r, input int op, input logic z, input logic mr, input logic res);
    @(negedge clk);
    rst = r; opcode = OP_W'(op); is_zero = z; mem_ready = mr; resume = res;
    #4;
  endtask

  task automatic lit(input string nm, input logic [10:0] exp);
    chk(nm, dut_vec(), exp);
  endtask

  initial begin
    cyc(0, 5, 0, 1, 0); lit("rst_hold", 11'h0);
    cyc(0, 5, 0, 1, 0);
    cyc(1, 5, 0, 1, 0); lit("reset_state", 11'h0);
    // LDA zero wait
    cyc(1, 5, 0, 1, 0); lit("lda_fetch", B_INC | B_RD | B_IR);
    cyc(1, 5, 0, 1, 0); lit("lda_decode", 11'h0);
    cyc(1, 5, 0, 1, 0); lit("lda_opfetch", B_SEL | B_RD | B_AC);
    // STO with 3 wait cycles
    cyc(1, 6, 0, 1, 0); lit("fetch_after_lda", B_INC | B_RD | B_IR);
    cyc(1, 6, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 6, 0, 0, 0); lit($sformatf("sto_wait%0d", i), B_SEL | B_WR | B_DE);
    end
    cyc(1, 6, 0, 1, 0); lit("sto_done", B_SEL | B_WR | B_DE);
    // SKZ taken / not taken, JMP
    cyc(1, 1, 1, 1, 0); lit("fetch_after_sto", B_INC | B_RD | B_IR);
    cyc(1, 1, 1, 1, 0); lit("skz_taken", B_INC);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0); lit("skz_not", 11'h0);
    cyc(1, 7, 0, 1, 0);
    cyc(1, 7, 0, 1, 0); lit("jmp", B_LDPC | B_SEL);
    cyc(1, 0, 0, 1, 1); lit("jmp_next_fetch", B_INC | B_RD | B_IR);
    // HLT and resume
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0); lit("hlt", B_HALT);
    cyc(1, 0, 0, 1, 1); lit("hlt_resume", B_HALT);
    cyc(1, 2, 0, 0, 0); lit("resume_fetch", B_RD);
    // ready on the limit cycle wins over the timeout
    for (int i = 0; i < 3; i++) cyc(1, 2, 0, 0, 0);
    cyc(1, 2, 0, 1, 0); lit("late_ready", B_INC | B_RD | B_IR);
    cyc(1, 2, 0, 1, 0);
    cyc(1, 2, 0, 0, 0);
    cyc(1, 2, 0, 1, 0); lit("add_ac", B_SEL | B_RD | B_AC);
    // async reset mid operand wait
    cyc(1, 5, 0, 1, 0);
    cyc(1, 5, 0, 1, 0);
    cyc(1, 5, 0, 0, 0);
    cyc(1, 5, 0, 0, 0); lit("opfetch_stall", B_SEL | B_RD);
    #3 rst = 1'b0;
    #1 lit("mid_reset", 11'h0);
    cyc(0, 5, 0, 0, 0);
    cyc(1, 5, 0, 0, 0); lit("release_reset", 11'h0);
    cyc(1, 5, 0, 0, 0); lit("release_fetch", B_RD);
    // fetch timeout with WAIT_MAX=4
    for (int i = 0; i < 3; i++) cyc(1, 5, 0, 0, 0);
    cyc(1, 5, 0, 0, 0); lit("to_last", B_RD);
    cyc(1, 5, 0, 0, 0); lit("to_halt", B_HALT | B_BERR);
    cyc(1, 5, 0, 0, 1); lit("to_resume", B_HALT | B_BERR);
    cyc(1, 5, 0, 0, 1); lit("to_stuck", B_HALT | B_BERR);
    // illegal opcode trap
    cyc(0, 10, 0, 1, 0); lit("rst_clears_err", 11'h0);
    cyc(1, 10, 0, 1, 0);
    cyc(1, 10, 0, 1, 0); lit("ill_fetch", B_INC | B_RD | B_IR);
    cyc(1, 10, 0, 1, 0); lit("ill_decode", 11'h0);
    cyc(1, 10, 0, 1, 0); lit("ill_halt", B_HALT | B_ILL);
    cyc(1, 10, 0, 1, 1); lit("ill_resume", B_HALT | B_ILL);
    cyc(1, 10, 0, 1, 1); lit("ill_stuck", B_HALT | B_ILL);
    cyc(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/risc_ctrl_mc.md
Name: risc_ctrl_mc

Overview:
- Second-generation multi-cycle controller for the accumulator RISC CPU. Same datapath strobes as the current controller.
- Adds a memory ready/wait handshake, a bus-timeout watchdog and a true HALT state with resume.
- Adds a parametrised opcode width with illegal-opcode trapping, and a skip that actually advances the PC.
- Sits between the instruction register / zero flag and the PC, memory, accumulator and bus-driver enables.

Parameters:
- OP_W, 3, opcode width. Opcodes 0..7 are the base ISA; any value >7 is illegal.
- WAIT_MAX, 15, maximum cycles a memory access may stall before bus_err. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  OP_W  opcode field from IR; valid from the cycle after ld_ir
- is_zero  in  1  accumulator zero flag
- mem_ready  in  1  memory completes the current rd/wr access this cycle
- resume  in  1  leave HALT (level-sampled)
- inc_pc  out  1  increment PC
- ld_pc  out  1  load PC from IR address
- sel  out  1  address mux: 0 = PC, 1 = IR address
- rd  out  1  memory read
- wr  out  1  memory write
- ld_ir  out  1  load instruction register
- ld_ac  out  1  load accumulator from ALU
- data_e  out  1  drive data bus from accumulator
- halted  out  1  controller in HALT
- bus_err  out  1  sticky, memory timeout
- illegal_op  out  1  sticky, undefined opcode decoded

Behaviour:
- States: S_RESET, S_FETCH, S_DECODE, S_OPFETCH, S_STORE, S_HALT.
- Register use:
  - The state register, wait counter, bus_err and illegal_op are registered.
  - All strobes are decoded combinationally from state and inputs.
  - Every strobe defaults to 0.
- While rst = 0: state = S_RESET, counter = 0, bus_err = 0, illegal_op = 0, all outputs 0.
- S_RESET: all outputs 0. Unconditional move to S_FETCH on the next edge.
- S_FETCH:
  - sel = 0, rd = 1.
  - If mem_ready: ld_ir = 1 and inc_pc = 1 in the same cycle, then -> S_DECODE.
- S_DECODE: no memory access. Dispatch on opcode:
  - 000 HLT -> S_HALT.
  - 001 SKZ: inc_pc = is_zero; -> S_FETCH.
  - 010 ADD, 011 AND, 100 XOR, 101 LDA -> S_OPFETCH.
  - 110 STO -> S_STORE.
  - 111 JMP: ld_pc = 1, sel = 1; -> S_FETCH.
  - Opcode >7 (only possible when OP_W > 3): set illegal_op, -> S_HALT.
- S_OPFETCH:
  - sel = 1, rd = 1.
  - If mem_ready: ld_ac = 1, then -> S_FETCH.
- S_STORE:
  - sel = 1, wr = 1, data_e = 1.
  - If mem_ready -> S_FETCH.
- S_HALT:
  - halted = 1.
  - If resume = 1 and bus_err = 0 and illegal_op = 0 -> S_FETCH.
  - Otherwise stay. Error halts are left only by reset.
- Wait counter, width $clog2(WAIT_MAX+1), minimum 1:
  - Counts cycles in a wait state (FETCH / OPFETCH / STORE) with mem_ready = 0.
  - Clears on every state change.
  - If WAIT_MAX > 0 and counter == WAIT_MAX and mem_ready = 0: set bus_err, -> S_HALT. The strobes for that cycle are still asserted.
  - The counter saturates and never wraps.
- Latency:
  - Zero-wait instruction: 2 cycles for HLT, SKZ, JMP; 3 cycles for ALU/LDA/STO.
  - Each wait cycle adds 1.
- Simultaneous events:
  - mem_ready arriving on the timeout cycle wins: no error, normal transition.
  - resume outside S_HALT is ignored.
  - An asynchronous reset in any state, including mid-wait, aborts the access immediately.
- Invariants:
  - rd and wr are never both 1.
  - data_e = 1 only together with wr.
  - ld_pc and inc_pc are never both 1.

Decomposition:
- Package risc_ctrl_pkg holds:
  - state_t enum (3 bits)
  - opcode localparams OP_HLT..OP_JMP
  - function is_wait_state(state_t)
- One sub-module, risc_wait_timer:
  - Parameter WAIT_MAX.
  - Inputs: clk, rst, active, ready, clear.
  - Output: timeout.
  - Holds the saturating counter.

Test Plan:
- Reset mid-wait: assert rst = 0 during S_OPFETCH with mem_ready = 0 -> all outputs 0 immediately. After release: one cycle S_RESET, then rd = 1, sel = 0.
- LDA, zero wait: mem_ready = 1 always, opcode = 101 -> cycle 1: rd, inc_pc, ld_ir. Cycle 2: all strobes 0. Cycle 3: sel, rd, ld_ac. Cycle 4: fetch resumes.
- STO with 3 wait cycles: mem_ready low for 3 cycles in S_STORE -> wr and data_e held 4 cycles, no bus_err, then fetch.
- Timeout: WAIT_MAX = 4, mem_ready stuck 0 in S_FETCH -> bus_err = 1 on the 5th cycle edge, halted = 1 after it. resume = 1 leaves halted = 1.
- SKZ/JMP: opcode 001 with is_zero = 1 -> inc_pc pulse in S_DECODE. Opcode 001 with is_zero = 0 -> no pulse. Opcode 111 -> ld_pc = 1, sel = 1 for 1 cycle, next cycle is fetch.
- HLT/resume and illegal opcode:
  - opcode 000 -> halted = 1. resume = 1 -> S_FETCH next edge.
  - OP_W = 4, opcode 1010 -> illegal_op = 1 and halted = 1, and resume is ignored.
